bsg_async_fifo_wptr: RTL

- Write-side pointer controller for an asynchronous FIFO, living entirely in the write clock domain.
- Keeps the registered binary and Gray write pointers and advances them on each accepted write.
- Exports the Gray write pointer for CDC transport to the read domain.
- Synchronizes the incoming read-domain Gray pointer and derives full (ready) and occupancy from it.

---
 rtl/bsg_async_fifo_wptr_pkg.sv | 24 ++
 rtl/bsg_gray_to_binary.sv | 18 +
 rtl/bsg_sync_2r.sv | 28 ++
 rtl/bsg_async_fifo_wptr.sv | 78 +++++++
 4 files changed

// File: rtl/bsg_async_fifo_wptr_pkg.sv
// Shared definitions for the async FIFO write-pointer slice.
// Holds the pointer-width helper and the Gray-code conversions.
package bsg_async_fifo_wptr_pkg;

    localparam int gray_max_width_lp = 32;

    function automatic int ptr_width(input int lg_size);
        return lg_size + 1;
    endfunction

    function automatic logic [gray_max_width_lp-1:0] bin2gray(input logic [gray_max_width_lp-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [gray_max_width_lp-1:0] gray2bin(input logic [gray_max_width_lp-1:0] gray);
        logic [gray_max_width_lp-1:0] bin;
        bin = {gray_max_width_lp{1'b0}};
        for (int i = 0; i < gray_max_width_lp; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/bsg_gray_to_binary.sv
// Parameterized Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at and above its position.
module bsg_gray_to_binary #(
    parameter int width_p = 4
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] bin_o
);

    // Prefix XOR from the MSB down.
    always_comb begin
        bin_o = {width_p{1'b0}};
        for (int i = 0; i < width_p; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/bsg_sync_2r.sv
// Standard two-flop synchronizer cell for a Gray-coded bus, synchronous
// active-low reset.
module bsg_sync_2r #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [width_p-1:0] meta_r;
    logic [width_p-1:0] sync_r;

    // Metastability-settling stage followed by the output stage.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            meta_r <= {width_p{1'b0}};
            sync_r <= {width_p{1'b0}};
        end else begin
            meta_r <= d_i;
            sync_r <= meta_r;
        end
    end

    assign q_o = sync_r;

endmodule

// File: rtl/bsg_async_fifo_wptr.sv
// Write-domain pointer controller for an asynchronous FIFO: binary/Gray
// write pointers, read-pointer synchronizer, full detection and occupancy.
module bsg_async_fifo_wptr
    import bsg_async_fifo_wptr_pkg::*;
#(
    parameter  int lg_size_p    = 3,
    localparam int ptr_width_lp = ptr_width(lg_size_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    w_v_i,
    output logic                    w_ready_o,
    output logic                    w_en_o,
    output logic [lg_size_p-1:0]    w_addr_o,
    output logic [ptr_width_lp-1:0] w_ptr_gray_o,
    input  logic [ptr_width_lp-1:0] r_ptr_gray_async_i,
    output logic [ptr_width_lp-1:0] r_ptr_gray_sync_o,
    output logic [ptr_width_lp-1:0] w_used_o
);

    // Full when the top two Gray bits differ and the rest match.
    localparam logic [ptr_width_lp-1:0] full_mask_lp = ptr_width_lp'(2'b11) << (ptr_width_lp - 2);

    logic [ptr_width_lp-1:0] w_bin_r;
    logic [ptr_width_lp-1:0] w_gray_r;
    logic [ptr_width_lp-1:0] w_bin_next_s;
    logic [ptr_width_lp-1:0] w_gray_next_s;
    logic [ptr_width_lp-1:0] r_sync_s;
    logic [ptr_width_lp-1:0] r_bin_s;
    logic                    full_s;
    logic                    w_accept_s;

    bsg_sync_2r #(
        .width_p (ptr_width_lp)
    ) r_ptr_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (r_ptr_gray_async_i),
        .q_o       (r_sync_s)
    );

    bsg_gray_to_binary #(
        .width_p (ptr_width_lp)
    ) r_ptr_g2b (
        .gray_i (r_sync_s),
        .bin_o  (r_bin_s)
    );

    // Next-pointer values, full detection and write acceptance.
    always_comb begin
        w_bin_next_s  = w_bin_r + ptr_width_lp'(1);
        w_gray_next_s = ptr_width_lp'(bin2gray(gray_max_width_lp'(w_bin_next_s)));
        full_s        = (w_gray_r == (r_sync_s ^ full_mask_lp));
        w_accept_s    = w_v_i & ~full_s;
    end

    // Pointer registers; the Gray copy is derived from the binary increment.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            w_bin_r  <= {ptr_width_lp{1'b0}};
            w_gray_r <= {ptr_width_lp{1'b0}};
        end else if (w_accept_s) begin
            w_bin_r  <= w_bin_next_s;
            w_gray_r <= w_gray_next_s;
        end else begin
            w_bin_r  <= w_bin_r;
            w_gray_r <= w_gray_r;
        end
    end

    assign w_ready_o         = ~full_s;
    assign w_en_o            = w_accept_s;
    assign w_addr_o          = w_bin_r[lg_size_p-1:0];
    assign w_ptr_gray_o      = w_gray_r;
    assign r_ptr_gray_sync_o = r_sync_s;
    assign w_used_o          = w_bin_r - r_bin_s;

endmodule
